// File: rtl/fifo_rd_streamer.sv
// Read-side controller for a 1-cycle-latency byte FIFO: credit-limited pops into a
// circular skid buffer, presented as a valid/ready stream. Optional byte counter: FIFO_RD_BYTE_CNT_EN.
module fifo_rd_streamer #(
  parameter int DATA_W    = 8,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic              busy_o
`ifdef FIFO_RD_BYTE_CNT_EN
  ,
  output logic [15:0]       byte_cnt_o
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  // Stream handshake: a byte transfers on any clk edge where m_valid_o & m_ready_i;
  // while m_valid_o=1 and m_ready_i=0, m_valid_o and m_data_o are held unchanged.

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     buf_cnt;
  logic              inflight, drop;
  logic              pop, push;
  logic [CW:0]       credit;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign m_valid_o = (buf_cnt != '0);
  assign m_data_o  = m_valid_o ? mem[head] : '0;
  assign pop       = m_valid_o & m_ready_i;
  // A byte returning during a flush cycle is discarded along with the buffer.
  assign push      = inflight & ~drop & ~flush_i;

  // Occupancy after this cycle's pop; a same-cycle pop frees a slot for 1 byte/clk.
  assign credit       = {1'b0, buf_cnt} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
  assign fifo_rd_en_o = ~rst & en_i & ~flush_i & ~fifo_empty_i &
                        (credit < (CW + 1)'(BUF_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt  <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else if (flush_i) begin
      buf_cnt  <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      drop     <= inflight;
    end else begin
      inflight <= fifo_rd_en_o;
      drop     <= 1'b0;
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push && !pop)      buf_cnt <= buf_cnt + CW'(1);
      else if (pop && !push) buf_cnt <= buf_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= fifo_data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = en_i ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (en_i) state_nxt = RUN;
        RUN:     if (!en_i) state_nxt = DRAIN;
        DRAIN: begin
          if (en_i)                                 state_nxt = RUN;
          else if (buf_cnt == '0 && !inflight)      state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy_o = (state != IDLE);

`ifdef FIFO_RD_BYTE_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          byte_cnt_o <= '0;
    else if (flush_i) byte_cnt_o <= '0;
    else if (pop)     byte_cnt_o <= byte_cnt_o + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural FIFO model, scoreboard of expected bytes,
// one task per scenario.
module tb_fifo_rd_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       flush = 1'b0;
  logic       ready = 1'b0;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_data = 8'h00;
  logic       m_valid;
  logic [7:0] m_data;
  logic       busy;
`ifdef FIFO_RD_BYTE_CNT_EN
  logic [15:0] byte_cnt;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int issue_total = 0;
  int pop_total = 0;
  int flush_base = 0;
  int wr_ptr = 0;
  int rd_ptr = 0;
  logic [7:0] fmem [0:1023];
  logic [7:0] exp_q [$];
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.DATA_W(8), .BUF_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .en_i         (en),
    .flush_i      (flush),
    .fifo_empty_i (fifo_empty),
    .fifo_rd_en_o (fifo_rd_en),
    .fifo_data_i  (fifo_data),
    .m_valid_o    (m_valid),
    .m_data_o     (m_data),
    .m_ready_i    (ready),
    .busy_o       (busy)
`ifdef FIFO_RD_BYTE_CNT_EN
    ,
    .byte_cnt_o   (byte_cnt)
`endif
  );

  // FIFO model: registered read data, one cycle after the strobe.
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
      fifo_data   <= fmem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
      issue_total <= issue_total + 1;
    end
  end

  // Scoreboard monitor: samples 1 time unit after the falling edge.
  always @(negedge clk) begin
    logic [7:0] e;
    #1;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      n_cmp++;
      if (fifo_rd_en && fifo_empty) begin
        n_fail++;
        $display("FAIL rd_while_empty: rd_en=%0b required 0", fifo_rd_en);
      end
      if (prev_hold) begin
        n_cmp++;
        if (m_valid !== 1'b1 || m_data !== prev_data) begin
          n_fail++;
          $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h", m_valid, m_data, prev_data);
        end
      end
      if (m_valid && ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: data=%02h required no output", m_data);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e) begin
            n_fail++;
            $display("FAIL stream_data: data=%02h required %02h", m_data, e);
          end
        end
        pop_total++;
      end
      prev_hold = m_valid && !ready && !flush;
      prev_data = m_data;
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fifo_push(input logic [7:0] b);
    fmem[wr_ptr] = b;
    wr_ptr++;
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b required 0", fifo_rd_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %02h required 00", m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
`ifdef FIFO_RD_BYTE_CNT_EN
    n_cmp++; if (byte_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_byte_cnt: got %0h required 0", byte_cnt); end
`endif
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b required 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d;
    en = 1'b1;
    ready = 1'b1;
    cyc();
    fifo_push(8'h11);
    fifo_push(8'h22);
    fifo_push(8'h33);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_cmp++;
      if (fifo_rd_en !== (k < 3)) begin
        n_fail++; $display("FAIL basic_issue[%0d]: got %0b required %0b", k, fifo_rd_en, (k < 3));
      end
      n_cmp++;
      if (m_valid !== (k >= 2 && k <= 4)) begin
        n_fail++; $display("FAIL basic_valid[%0d]: got %0b required %0b", k, m_valid, (k >= 2 && k <= 4));
      end
      exp_d = (k >= 2 && k <= 4) ? 8'(8'h11 * (k - 1)) : 8'h00;
      n_cmp++;
      if (m_data !== exp_d) begin
        n_fail++; $display("FAIL basic_data[%0d]: got %02h required %02h", k, m_data, exp_d);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int base, p0, last, gap_max, cycles;
    ready = 1'b0;
    cyc();
    base = issue_total;
    for (int i = 0; i < 5; i++) fifo_push(8'h40 + 8'(i));
    repeat (6) cyc();
    #1;
    n_cmp++;
    if (issue_total - base !== 2) begin
      n_fail++; $display("FAIL bp_issues: got %0d required 2", issue_total - base);
    end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h40) begin
      n_fail++; $display("FAIL bp_head: valid=%0b data=%02h required valid=1 data=40", m_valid, m_data);
    end
    cyc();
    ready = 1'b1;
    p0 = pop_total;
    last = 0;
    gap_max = 0;
    cycles = 0;
    while ((pop_total - p0) < 5 && cycles < 40) begin
      #2;
      if (pop_total != p0 + 0 && (pop_total - p0) > 0 && cycles - last > gap_max && last >= 0) begin
        gap_max = (pop_total - p0 == 1) ? 0 : cycles - last;
      end
      if ((pop_total - p0) > 0) last = cycles;
      cyc();
      cycles++;
    end
    n_cmp++;
    if (pop_total - p0 !== 5) begin
      n_fail++; $display("FAIL bp_count: got %0d required 5", pop_total - p0);
    end
    n_cmp++;
    if (gap_max > 2) begin
      n_fail++; $display("FAIL bp_gap: got %0d clk required <= 2", gap_max);
    end
  endtask

  task automatic test_random();
    int p0, next, cycles;
    en = 1'b1;
    p0 = pop_total;
    next = 0;
    cycles = 0;
    while ((pop_total - p0) < 256 && cycles < 4000) begin
      cyc();
      ready = 1'($urandom_range(0, 1));
      if (next < 256 && $urandom_range(0, 2) != 0) begin
        fifo_push(8'(next));
        next++;
      end
      cycles++;
    end
    cyc();
    ready = 1'b1;
    n_cmp++;
    if (pop_total - p0 !== 256) begin
      n_fail++; $display("FAIL rand_count: got %0d required 256", pop_total - p0);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL rand_leftover: got %0d required 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    int t;
    logic [7:0] dropped;
    en = 1'b1;
    ready = 1'b0;
    cyc();
    fifo_push(8'hA5);
    t = 0;
    #1;
    while (!m_valid && t < 10) begin cyc(); #1; t++; end
    n_cmp++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL flush_prefill: valid=%0b required 1", m_valid); end
    cyc();
    fifo_push(8'h5A);
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL flush_pre_issue: got %0b required 1", fifo_rd_en); end
    cyc();
    flush = 1'b1;
    fifo_push(8'h3C);
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue: got %0b required 0", fifo_rd_en); end
    dropped = exp_q.pop_front();
    dropped = exp_q.pop_front();
    cyc();
    flush = 1'b0;
    #1;
    flush_base = pop_total;
    n_cmp++;
    if (m_valid !== 1'b0 || m_data !== 8'h00) begin
      n_fail++; $display("FAIL flush_clear: valid=%0b data=%02h required valid=0 data=00", m_valid, m_data);
    end
`ifdef FIFO_RD_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 16'h0) begin n_fail++; $display("FAIL flush_byte_cnt: got %0h required 0", byte_cnt); end
`endif
    cyc();
    ready = 1'b1;
    t = 0;
    #1;
    while (!m_valid && t < 10) begin cyc(); #1; t++; end
    n_cmp++;
    if (m_valid !== 1'b1 || m_data !== 8'h3C) begin
      n_fail++; $display("FAIL flush_next: valid=%0b data=%02h required valid=1 data=3c (last dropped %02h)", m_valid, m_data, dropped);
    end
    cyc();
  endtask

  task automatic test_en_drop();
    int ib, pb, exp_rem, n, t;
    ready = 1'b0;
    cyc();
    ib = issue_total;
    pb = pop_total;
    fifo_push(8'hD0);
    fifo_push(8'hD1);
    fifo_push(8'hD2);
    cyc();
    cyc();
    en = 1'b0;
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL endrop_issue: got %0b required 0", fifo_rd_en); end
    cyc();
    exp_rem = (issue_total - ib) - (pop_total - pb);
    ready = 1'b1;
    n = 0;
    t = 0;
    #1;
    while (m_valid && t < 10) begin n++; t++; cyc(); #1; end
    n_cmp++;
    if (n !== exp_rem || n !== 2) begin
      n_fail++; $display("FAIL endrop_delivered: got %0d required %0d", n, exp_rem);
    end
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL endrop_busy_hold: got %0b required 1", busy); end
    cyc();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL endrop_busy_fall: got %0b required 0", busy); end
    n_cmp++;
    if (wr_ptr - rd_ptr !== 1) begin n_fail++; $display("FAIL endrop_fifo_left: got %0d required 1", wr_ptr - rd_ptr); end
`ifdef FIFO_RD_BYTE_CNT_EN
    n_cmp++;
    if (byte_cnt !== 16'(pop_total - flush_base)) begin
      n_fail++; $display("FAIL endrop_byte_cnt: got %0d required %0d", byte_cnt, pop_total - flush_base);
    end
`endif
    cyc();
    en = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin cyc(); t++; end
    n_cmp++;
    if (exp_q.size() !== 0) begin n_fail++; $display("FAIL endrop_tail: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    ready = 1'b1;
    cyc();
    for (int i = 0; i < 6; i++) fifo_push(8'h70 + 8'(i));
    repeat (3) cyc();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_rd_en: got %0b required 0", fifo_rd_en); end
    n_cmp++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b required 0", m_valid); end
    n_cmp++; if (m_data !== 8'h00) begin n_fail++; $display("FAIL arst_data: got %02h required 00", m_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %0b required 0", busy); end
`ifdef FIFO_RD_BYTE_CNT_EN
    n_cmp++; if (byte_cnt !== 16'h0) begin n_fail++; $display("FAIL arst_byte_cnt: got %0h required 0", byte_cnt); end
`endif
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      n_cmp++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL arst_hold_issue[%0d]: got %0b required 0", i, fifo_rd_en); end
    end
    cyc();
    ready = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL arst_resume: got %0b required 1", fifo_rd_en); end
    repeat (3) cyc();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_flush();
    test_en_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
